// File: rtl/multi_context_connection_block_if.sv
// Config-chain and context-switch handshake bundle for multi_context_connection_block.
// The master drives the serial chain and switch strobe; the slave is the connection block.
interface multi_context_connection_block_if #(
    parameter int NCTX = 2
);
    localparam int CTXW = (NCTX > 1) ? $clog2(NCTX) : 1;

    logic            cfg_start;
    logic [CTXW-1:0] cfg_wr_ctx;
    logic            cfg_bit;
    logic            cfg_valid;
    logic            cfg_ready;
    logic            cfg_done;
    logic            ctx_switch;
    logic [CTXW-1:0] ctx_sel;
    logic [CTXW-1:0] active_ctx;

    modport master (
        output cfg_start, cfg_wr_ctx, cfg_bit, cfg_valid, ctx_switch, ctx_sel,
        input  cfg_ready, cfg_done, active_ctx
    );

    modport slave (
        input  cfg_start, cfg_wr_ctx, cfg_bit, cfg_valid, ctx_switch, ctx_sel,
        output cfg_ready, cfg_done, active_ctx
    );
endinterface

// File: rtl/multi_context_connection_block.sv
// Multi-context connection block: NCTX serially loaded routing contexts, one active at a time.
// Define CONN_OUTREG_EN to register north_out, south_out and data_input.
module multi_context_connection_block #(
    parameter int W       = 16,
    parameter int WW      = 8,
    parameter int DATAIN  = 8,
    parameter int DATAOUT = 16,
    parameter int NCTX    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    multi_context_connection_block_if.slave cfg,
    input  logic [W-1:0]             north_in,
    input  logic [W-1:0]             south_in,
    output logic [W-1:0]             north_out,
    output logic [W-1:0]             south_out,
    output logic [WW*DATAIN-1:0]     data_input,
    input  logic [WW*DATAOUT-1:0]    data_output
);
    localparam int WN          = W / WW;
    localparam int SEL_PER_IN  = $clog2(2 * WN);
    localparam int SEL_PER_OUT = $clog2(DATAOUT + 1);
    localparam int BASE        = SEL_PER_IN * DATAIN * WW;
    localparam int CONF_WIDTH  = BASE + SEL_PER_OUT * 2 * W;
    localparam int CTXW        = (NCTX > 1) ? $clog2(NCTX) : 1;
    localparam int CNTW        = $clog2(CONF_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CONF_WIDTH-1:0]   shadow;
    logic [CNTW-1:0]         bit_cnt;
    logic [CTXW-1:0]         wr_ctx;
    logic [CTXW-1:0]         active_ctx;
    logic [CONF_WIDTH-1:0]   ctx_mem [NCTX];
    logic [CONF_WIDTH-1:0]   act_conf;
    logic                    accept;
    logic                    start_ok;
    logic                    switch_ok;
    logic [SEL_PER_IN-1:0]   in_sel;
    logic [SEL_PER_OUT-1:0]  n_sel;
    logic [SEL_PER_OUT-1:0]  s_sel;
    logic [W-1:0]            north_c;
    logic [W-1:0]            south_c;
    logic [WW*DATAIN-1:0]    data_in_c;

    // Requests naming a context that does not exist are dropped outright.
    assign start_ok  = cfg.cfg_start  && ({1'b0, cfg.cfg_wr_ctx} < (CTXW+1)'(NCTX));
    assign switch_ok = cfg.ctx_switch && ({1'b0, cfg.ctx_sel}    < (CTXW+1)'(NCTX));
    assign accept    = cfg.cfg_valid && (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        cfg.cfg_ready = 1'b0;
        cfg.cfg_done  = 1'b0;
        case (state)
            IDLE:   if (start_ok) state_next = SHIFT;
            SHIFT: begin
                cfg.cfg_ready = 1'b1;
                if (cfg.cfg_valid && (bit_cnt == CNTW'(CONF_WIDTH - 1))) state_next = COMMIT;
            end
            COMMIT: begin
                cfg.cfg_done = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Commit and switch use separate registers, so a same-cycle pair both land.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow     <= '0;
            bit_cnt    <= '0;
            wr_ctx     <= '0;
            active_ctx <= '0;
            for (int c = 0; c < NCTX; c++) ctx_mem[c] <= '0;
        end else begin
            if ((state == IDLE) && start_ok) wr_ctx <= cfg.cfg_wr_ctx;
            if (accept) begin
                shadow  <= {cfg.cfg_bit, shadow[CONF_WIDTH-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == COMMIT) begin
                ctx_mem[wr_ctx] <= shadow;
                bit_cnt         <= '0;
            end
            if (switch_ok) active_ctx <= cfg.ctx_sel;
        end
    end

    assign cfg.active_ctx = active_ctx;
    assign act_conf       = ctx_mem[active_ctx];

    always_comb begin
        in_sel    = '0;
        n_sel     = '0;
        s_sel     = '0;
        data_in_c = '0;
        north_c   = '0;
        south_c   = '0;
        for (int i = 0; i < DATAIN; i++) begin
            for (int j = 0; j < WW; j++) begin
                in_sel = act_conf[SEL_PER_IN*(i*WW+j) +: SEL_PER_IN];
                for (int k = 0; k < WN; k++) begin
                    if (in_sel == SEL_PER_IN'(2*k))   data_in_c[i*WW+j] = north_in[k*WW+j];
                    if (in_sel == SEL_PER_IN'(2*k+1)) data_in_c[i*WW+j] = south_in[k*WW+j];
                end
            end
        end
        // Select 0 is the straight-through path; selects past DATAOUT leave the track at 0.
        for (int n = 0; n < W; n++) begin
            n_sel = act_conf[BASE + SEL_PER_OUT*(2*n)   +: SEL_PER_OUT];
            s_sel = act_conf[BASE + SEL_PER_OUT*(2*n+1) +: SEL_PER_OUT];
            if (n_sel == '0) north_c[n] = south_in[n];
            if (s_sel == '0) south_c[n] = north_in[n];
            for (int s = 1; s <= DATAOUT; s++) begin
                if (n_sel == SEL_PER_OUT'(s)) north_c[n] = data_output[(s-1)*WW + (n % WW)];
                if (s_sel == SEL_PER_OUT'(s)) south_c[n] = data_output[(s-1)*WW + (n % WW)];
            end
        end
    end

`ifdef CONN_OUTREG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            north_out  <= '0;
            south_out  <= '0;
            data_input <= '0;
        end else begin
            north_out  <= north_c;
            south_out  <= south_c;
            data_input <= data_in_c;
        end
    end
`else
    assign north_out  = north_c;
    assign south_out  = south_c;
    assign data_input = data_in_c;
`endif
endmodule

// File: tb/tb_multi_context_connection_block.sv
// Self-checking bench for multi_context_connection_block: directed tables, corner sequences
// and randomized contexts checked against a select-array reference model.
module tb_multi_context_connection_block;
    localparam int W          = 16;
    localparam int WW         = 8;
    localparam int DATAIN     = 8;
    localparam int DATAOUT    = 16;
    localparam int NCTX       = 2;
    localparam int WN         = W / WW;
    localparam int NIN        = DATAIN * WW;
    localparam int SPI        = 2;
    localparam int SPO        = 5;
    localparam int BASE       = SPI * NIN;
    localparam int CONF_WIDTH = 288;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [W-1:0]           north_in, south_in;
    logic [W-1:0]           north_out, south_out, north_out3, south_out3;
    logic [NIN-1:0]         data_input, data_input3;
    logic [WW*DATAOUT-1:0]  data_output;

    multi_context_connection_block_if #(.NCTX(2)) bif ();
    multi_context_connection_block_if #(.NCTX(3)) bif3 ();

    multi_context_connection_block #(
        .W(W), .WW(WW), .DATAIN(DATAIN), .DATAOUT(DATAOUT), .NCTX(2)
    ) dut (
        .clk(clk), .rst(rst), .cfg(bif.slave),
        .north_in(north_in), .south_in(south_in),
        .north_out(north_out), .south_out(south_out),
        .data_input(data_input), .data_output(data_output)
    );

    multi_context_connection_block #(
        .W(W), .WW(WW), .DATAIN(DATAIN), .DATAOUT(DATAOUT), .NCTX(3)
    ) dut3 (
        .clk(clk), .rst(rst), .cfg(bif3.slave),
        .north_in(north_in), .south_in(south_in),
        .north_out(north_out3), .south_out(south_out3),
        .data_input(data_input3), .data_output(data_output)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                    phase;
        logic [W-1:0]          n_in;
        logic [W-1:0]          s_in;
        logic [WW*DATAOUT-1:0] d_out;
        logic [W-1:0]          exp_no;
        logic [W-1:0]          exp_so;
        logic [WW-1:0]         exp_byte;
    } vec_t;

    vec_t vecs [6];

    // Reference model: each context is a list of select values per destination.
    int m_in [NCTX][NIN];
    int m_no [NCTX][W];
    int m_so [NCTX][W];
    int m_active;
    int p_in [NIN];
    int p_no [W];
    int p_so [W];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [NIN-1:0] exp_data_input(input int c);
        logic [NIN-1:0] r;
        int sel;
        int k;
        r = '0;
        for (int idx = 0; idx < NIN; idx++) begin
            sel = m_in[c][idx];
            k   = sel / 2;
            if (sel < 2*WN)
                r[idx] = (sel % 2 == 1) ? south_in[k*WW + idx%WW] : north_in[k*WW + idx%WW];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] exp_track(input int c, input bit is_north);
        logic [W-1:0] r;
        int sel;
        r = '0;
        for (int n = 0; n < W; n++) begin
            sel = is_north ? m_no[c][n] : m_so[c][n];
            if (sel == 0)            r[n] = is_north ? south_in[n] : north_in[n];
            else if (sel <= DATAOUT) r[n] = data_output[(sel-1)*WW + n%WW];
        end
        return r;
    endfunction

    function automatic logic [CONF_WIDTH-1:0] build_stream();
        logic [CONF_WIDTH-1:0] st;
        st = '0;
        for (int idx = 0; idx < NIN; idx++) st[SPI*idx +: SPI] = SPI'(p_in[idx]);
        for (int n = 0; n < W; n++) begin
            st[BASE + SPO*(2*n)   +: SPO] = SPO'(p_no[n]);
            st[BASE + SPO*(2*n+1) +: SPO] = SPO'(p_so[n]);
        end
        return st;
    endfunction

    function automatic void clear_model();
        for (int c = 0; c < NCTX; c++) begin
            for (int i = 0; i < NIN; i++) m_in[c][i] = 0;
            for (int n = 0; n < W; n++) begin
                m_no[c][n] = 0;
                m_so[c][n] = 0;
            end
        end
        m_active = 0;
    endfunction

    function automatic void commit_model(input int c);
        for (int i = 0; i < NIN; i++) m_in[c][i] = p_in[i];
        for (int n = 0; n < W; n++) begin
            m_no[c][n] = p_no[n];
            m_so[c][n] = p_so[n];
        end
    endfunction

    function automatic void set_pattern(input int in_v, input int no_v, input int so_v);
        for (int i = 0; i < NIN; i++) p_in[i] = in_v;
        for (int n = 0; n < W; n++) begin
            p_no[n] = no_v;
            p_so[n] = so_v;
        end
    endfunction

    function automatic void random_pattern();
        for (int i = 0; i < NIN; i++) p_in[i] = int'($urandom_range(0, 3));
        for (int n = 0; n < W; n++) begin
            p_no[n] = int'($urandom_range(0, 31));
            p_so[n] = int'($urandom_range(0, 31));
        end
    endfunction

    task automatic applyStimulus(input logic [W-1:0] n, input logic [W-1:0] s, input logic [WW*DATAOUT-1:0] d);
        north_in    = n;
        south_in    = s;
        data_output = d;
        @(posedge clk); #1;
    endtask

    task automatic check_routing(input string name);
        checkOutput({name, "_north_out"},  128'(north_out),  128'(exp_track(m_active, 1'b1)));
        checkOutput({name, "_south_out"},  128'(south_out),  128'(exp_track(m_active, 1'b0)));
        checkOutput({name, "_data_input"}, 128'(data_input), 128'(exp_data_input(m_active)));
    endtask

    task automatic run_table(input int phase, input string name);
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].phase == phase) begin
                applyStimulus(vecs[i].n_in, vecs[i].s_in, vecs[i].d_out);
                checkOutput({name, "_north_out"},  128'(north_out),  128'(vecs[i].exp_no));
                checkOutput({name, "_south_out"},  128'(south_out),  128'(vecs[i].exp_so));
                checkOutput({name, "_data_input"}, 128'(data_input), 128'({DATAIN{vecs[i].exp_byte}}));
            end
        end
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        bif.cfg_start   = 1'b0;
        bif.cfg_valid   = 1'b0;
        bif.cfg_bit     = 1'b0;
        bif.ctx_switch  = 1'b0;
        bif3.cfg_start  = 1'b0;
        bif3.ctx_switch = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
    endtask

    task automatic switch_ctx(input int c);
        bif.ctx_switch = 1'b1;
        bif.ctx_sel    = 1'(c);
        @(posedge clk); #1;
        bif.ctx_switch = 1'b0;
        if (c < NCTX) m_active = c;
        checkOutput("switch_active_ctx", 128'(bif.active_ctx), 128'(m_active));
    endtask

    // mode: 0 continuous valid, 1 toggling valid, 2 random valid.
    task automatic load_ctx(input int ctx, input int mode, input int abort_at,
                            input int poke_at, input bit sw_at_commit);
        logic [CONF_WIDTH-1:0] st;
        int  accepts;
        int  cycles;
        int  early;
        bit  v;
        bit  acc;
        bit  tog;
        st      = build_stream();
        accepts = 0;
        cycles  = 0;
        early   = 0;
        tog     = 1'b0;
        bif.cfg_start  = 1'b1;
        bif.cfg_wr_ctx = 1'(ctx);
        @(posedge clk); #1;
        bif.cfg_start = 1'b0;
        checkOutput("ready_after_start", 128'(bif.cfg_ready), 128'(1));
        while (accepts < CONF_WIDTH && cycles < 4*CONF_WIDTH) begin
            if (abort_at >= 0 && accepts == abort_at) begin
                do_reset();
                checkOutput("abort_ready", 128'(bif.cfg_ready), 128'(0));
                checkOutput("abort_done",  128'(bif.cfg_done),  128'(0));
                checkOutput("abort_early_done", 128'(early), 128'(0));
                @(posedge clk); #1;
                checkOutput("abort_no_late_done", 128'(bif.cfg_done), 128'(0));
                return;
            end
            if (poke_at >= 0 && accepts == poke_at) begin
                bif.cfg_start  = 1'b1;
                bif.cfg_wr_ctx = 1'(1 - ctx);
            end
            case (mode)
                0:       v = 1'b1;
                1: begin v = tog; tog = ~tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            bif.cfg_valid = v;
            bif.cfg_bit   = st[accepts];
            if (bif.cfg_done) early++;
            acc = v && bif.cfg_ready;
            @(posedge clk); #1;
            bif.cfg_start = 1'b0;
            if (acc) accepts++;
            cycles++;
        end
        bif.cfg_valid = 1'b0;
        if (accepts < CONF_WIDTH) begin
            checkOutput("load_timeout_accepts", 128'(accepts), 128'(CONF_WIDTH));
            return;
        end
        checkOutput("no_early_done", 128'(early), 128'(0));
        checkOutput("done_after_last_accept", 128'(bif.cfg_done), 128'(1));
        checkOutput("ready_low_in_commit", 128'(bif.cfg_ready), 128'(0));
        if (sw_at_commit) begin
            bif.ctx_switch = 1'b1;
            bif.ctx_sel    = 1'(ctx);
        end
        @(posedge clk); #1;
        bif.ctx_switch = 1'b0;
        commit_model(ctx);
        if (sw_at_commit) begin
            m_active = ctx;
            checkOutput("switch_with_commit_active", 128'(bif.active_ctx), 128'(m_active));
        end
        checkOutput("done_single_pulse", 128'(bif.cfg_done), 128'(0));
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{0, 16'hA5C3, 16'h1234, 128'h0, 16'h1234, 16'hA5C3, 8'hC3};
        vecs[1] = '{0, 16'h0000, 16'hFFFF, 128'h0, 16'hFFFF, 16'h0000, 8'h00};
        vecs[2] = '{0, 16'h8001, 16'h7E18, 128'h0, 16'h7E18, 16'h8001, 8'h01};
        vecs[3] = '{1, 16'hA5C3, 16'h1234, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_325A, 16'h5A5A, 16'hA5C3, 8'h12};
        vecs[4] = '{1, 16'hFFFF, 16'h0000, 128'hFFFF_0000_FFFF_0000_1111_2222_3333_4400, 16'h0000, 16'hFFFF, 8'h00};
        vecs[5] = '{1, 16'h0F0F, 16'hC33C, 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E181, 16'h8181, 16'h0F0F, 8'hC3};

        bif.cfg_wr_ctx  = '0;
        bif.ctx_sel     = '0;
        bif3.cfg_wr_ctx = '0;
        bif3.ctx_sel    = '0;
        bif3.cfg_bit    = 1'b0;
        bif3.cfg_valid  = 1'b0;
        north_in    = 16'hA5C3;
        south_in    = 16'h1234;
        data_output = '0;
        do_reset();

        // Reset state and pass-through routing of the all-zero context
        checkOutput("reset_cfg_ready",  128'(bif.cfg_ready),  128'(0));
        checkOutput("reset_cfg_done",   128'(bif.cfg_done),   128'(0));
        checkOutput("reset_active_ctx", 128'(bif.active_ctx), 128'(0));
        run_table(0, "reset_table");

        // Full load into context 1, inactive until switched to
        set_pattern(3, 1, 0);
        load_ctx(1, 0, -1, -1, 1'b0);
        applyStimulus(16'hA5C3, 16'h1234, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_325A);
        check_routing("inactive_ctx1");
        switch_ctx(1);
        run_table(1, "ctx1_table");

        // Backpressured load of the same routing into context 0
        load_ctx(0, 1, -1, -1, 1'b0);
        switch_ctx(0);
        run_table(1, "backpressure_table");

        // Mid-load cfg_start naming context 0 must not redirect the write away from context 1
        set_pattern(2, 17, 31);
        load_ctx(1, 0, -1, 50, 1'b0);
        run_table(1, "ctx0_untouched");
        switch_ctx(1);
        applyStimulus(16'h3CA5, 16'h96E1, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        check_routing("poked_ctx1");

        // Reset in the middle of a load clears everything and needs a fresh full load
        set_pattern(1, 2, 3);
        load_ctx(0, 0, 100, -1, 1'b0);
        run_table(0, "after_abort_table");
        set_pattern(3, 1, 0);
        load_ctx(0, 0, -1, -1, 1'b0);
        run_table(1, "reload_table");

        // Out-of-range context requests on a three-context build
        bif3.ctx_switch = 1'b1;
        bif3.ctx_sel    = 2'd2;
        @(posedge clk); #1;
        checkOutput("nctx3_switch_ctx2", 128'(bif3.active_ctx), 128'(2));
        bif3.ctx_sel = 2'd3;
        @(posedge clk); #1;
        bif3.ctx_switch = 1'b0;
        checkOutput("nctx3_switch_ctx3_ignored", 128'(bif3.active_ctx), 128'(2));
        bif3.cfg_start  = 1'b1;
        bif3.cfg_wr_ctx = 2'd3;
        @(posedge clk); #1;
        bif3.cfg_start = 1'b0;
        checkOutput("nctx3_start_ctx3_ignored", 128'(bif3.cfg_ready), 128'(0));
        bif3.cfg_start  = 1'b1;
        bif3.cfg_wr_ctx = 2'd2;
        @(posedge clk); #1;
        bif3.cfg_start = 1'b0;
        checkOutput("nctx3_start_ctx2", 128'(bif3.cfg_ready), 128'(1));

        // Randomized contexts with random handshake gaps against the model
        for (int r = 0; r < 4; r++) begin
            random_pattern();
            load_ctx(r % 2, 2, -1, -1, (r == 1));
            if (r != 1) switch_ctx(r % 2);
            for (int t = 0; t < 5; t++) begin
                applyStimulus(16'($urandom), 16'($urandom),
                              {$urandom, $urandom, $urandom, $urandom});
                check_routing("random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/multi_context_connection_block.md
Name: multi_context_connection_block

Overview:
- Unidirectional-fabric connection block joining north/south routing tracks to MAC data inputs and outputs.
- Holds NCTX complete routing configurations and switches between them with a one-cycle strobe.
- Each configuration is loaded through a serial config chain with a valid/ready handshake and a load FSM.
- Configuration layout and per-bit routing semantics match the single-context data connection block.

Parameters:
- W, 16, fabric tracks per direction (multiple of WW)
- WW, 8, word width
- DATAIN, 8, MAC input words
- DATAOUT, 16, MAC output words
- NCTX, 2, number of stored contexts (>=1)
- Derived localparams:
  - WN = W/WW
  - SEL_PER_IN = clog2(2*WN)
  - SEL_PER_OUT = clog2(DATAOUT+1)
  - CONF_WIDTH = SEL_PER_IN*DATAIN*WW + SEL_PER_OUT*2*W
  - CTXW = max(1, clog2(NCTX))
  - CNTW = clog2(CONF_WIDTH+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high; clock clk
- cfg_start  in  1  begin loading a context (honoured only in IDLE)
- cfg_wr_ctx  in  CTXW  target context, captured with cfg_start
- cfg_bit  in  1  serial config data
- cfg_valid  in  1  cfg_bit valid
- cfg_ready  out  1  chain accepting bits
- cfg_done  out  1  one-cycle pulse when a context has been written
- ctx_switch  in  1  strobe that selects a new active context
- ctx_sel  in  CTXW  context requested by ctx_switch
- active_ctx  out  CTXW  current active context
- north_in, south_in  in  W  fabric inputs
- north_out, south_out  out  W  fabric outputs
- data_input  out  WW*DATAIN  to MAC
- data_output  in  WW*DATAOUT  from MAC

Behaviour:
- Reset values:
  - FSM=IDLE, bit counter=0, shadow register=0
  - all NCTX contexts=0, active_ctx=0
  - cfg_ready=0, cfg_done=0
- FSM IDLE -> SHIFT:
  - transition on cfg_start; latch cfg_wr_ctx.
  - If cfg_wr_ctx >= NCTX, stay in IDLE and ignore the request.
- SHIFT:
  - cfg_ready=1.
  - Each cycle with cfg_valid&&cfg_ready: shadow <= {cfg_bit, shadow[CONF_WIDTH-1:1]}, counter+1. The first bit sent lands in shadow bit 0.
  - On the accept that brings the counter to CONF_WIDTH, go to COMMIT.
  - cfg_start is ignored while in SHIFT.
- COMMIT (one cycle):
  - cfg_ready=0; context[latched ctx] <= shadow.
  - cfg_done=1 in this cycle.
  - Counter clears; next state is IDLE.
- Context switch:
  - ctx_switch with ctx_sel<NCTX sets active_ctx on the next edge; ctx_sel>=NCTX is ignored.
  - Switch and commit in the same cycle: both take effect.
  - Writing into the active context changes routing on the cycle after COMMIT.
- Routing is combinational from the active context C. For this context:
  - data_input[i*WW+j] uses sel field C[SEL_PER_IN*(i*WW+j) +: SEL_PER_IN].
    - Candidate 2k = north_in[k*WW+j]; candidate 2k+1 = south_in[k*WW+j].
    - A sel value >= 2*WN drives 0.
  - Output select fields start at BASE = SEL_PER_IN*DATAIN*WW. For track n = k*WW+j:
    - north_out[n] uses field index 2n.
    - south_out[n] uses field index 2n+1.
    - Each field is SEL_PER_OUT bits at BASE + SEL_PER_OUT*index.
  - Output sel decode:
    - sel=0 passes straight through: north_out takes south_in[n]; south_out takes north_in[n].
    - sel=s in 1..DATAOUT selects data_output[(s-1)*WW+j].
    - sel > DATAOUT drives 0.
- Reset mid-load aborts the load. The shadow register, counter and contexts clear, and no cfg_done is issued.

Optional Feature:
- Macro CONN_OUTREG_EN.
- Defined: north_out, south_out and data_input are registered.
  - Adds 1-cycle latency from inputs and from context changes.
  - Registers reset to 0.
- Undefined: purely combinational outputs, zero latency.

Test Plan:
All cases use W=16, WW=8, DATAIN=8, DATAOUT=16, NCTX=2, which gives CONF_WIDTH=288. CONN_OUTREG_EN is off unless noted.
1. Reset: release rst with north_in=16'hA5C3, south_in=16'h1234 -> north_out=16'h1234, south_out=16'hA5C3, every data_input byte=8'hC3, cfg_ready=0, active_ctx=0.
2. Load context 1: all input sels=3, all north_out sels=1, all south_out sels=0, 288 bits, continuous valid.
   - cfg_done pulses once, on the cycle after the 288th accept.
   - Outputs are unchanged while active_ctx=0.
   - After ctx_switch with ctx_sel=1: data_input bytes=8'h12; north_out={2{data_output[7:0]}}; south_out=16'hA5C3.
3. Backpressure: cfg_valid toggles every cycle -> counter advances only on accepts; cfg_done occurs after exactly 288 accepts, never earlier; routing matches test 2.
4. Out-of-range selects: input sel=2'b11 with WN=2 is legal (south high byte); north_out sel=31 -> north_out=0.
   - NCTX=3 build: ctx_sel=3 with ctx_switch -> active_ctx unchanged.
   - cfg_start with cfg_wr_ctx=3 -> stays IDLE, cfg_ready=0.
5. Reset after 100 accepted bits -> cfg_ready=0 and no cfg_done. A new full 288-bit load is then required, and cfg_done follows the 288th accept.
6. cfg_start pulsed mid-SHIFT with a different cfg_wr_ctx -> ignored; the original context is written.
   - CONN_OUTREG_EN build: repeat test 1; outputs appear one cycle after the inputs change.
